// File: rtl/lfsr_prng.sv
// ---------------------------------------------------------------------------
// lfsr_prng
//
// Parametrised LFSR pseudo-random generator with a bounded-index stage.
// The LFSR runs in Fibonacci (MODE=0) or Galois (MODE=1) form. Each advance
// applies STEPS single steps, unrolled in one combinational chain. A rejection
// sampler turns the low IDX_W bits of the advanced state into a uniform index
// in [0, limit). Cache-way replacement and TLB-random logic consume it.
//
// Parameters
//   WIDTH  LFSR state width (>= 2)
//   TAPS   feedback tap mask, WIDTH bits
//   MODE   0 = Fibonacci, 1 = Galois
//   SEED   reset / lock-up recovery state, must be non-zero
//   STEPS  single steps per advance (>= 1)
//   IDX_W  bounded-index width (1..WIDTH)
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   update     request a new random value / index
//   load       load load_val into the state (a zero value loads SEED)
//   load_val   seed to load
//   limit      index bound; 0 means the full range 2^IDX_W
//   val        current LFSR state (registered)
//   rand_idx   bounded random index (registered)
//   idx_ok     rand_idx is fresh and the block is idle (registered)
//   state_dbg  FSM state, 0 = IDLE, 1 = RETRY (debug observation only)
//
// Request/response handshake:
//   The consumer pulses update (a request) only while idx_ok=1. The block
//   advances on that clock. If the candidate index is accepted, idx_ok stays
//   1 and rand_idx holds the new index on the following cycle. Otherwise
//   idx_ok drops to 0 and the block keeps advancing on its own until a
//   candidate is accepted. At that point idx_ok returns to 1 with the fresh
//   rand_idx. While idx_ok=0, rand_idx is stale and must not be used, and
//   update is ignored. A load aborts any pending retry and raises idx_ok
//   without touching rand_idx.
// ---------------------------------------------------------------------------
module lfsr_prng #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = 32'h0820_0005,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = 32'hDEAD_FACE,
  parameter int               STEPS = 1,
  parameter int               IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [IDX_W-1:0] limit,
  output logic [WIDTH-1:0] val,
  output logic [IDX_W-1:0] rand_idx,
  output logic             idx_ok,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    RETRY = 1'b1
  } state_t;

  state_t state_q;

  // One LFSR iteration in the selected form.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    if (MODE == 0) begin
      // Fibonacci: parity of the tapped bits shifts in at the top.
      fb        = ^(s & TAPS);
      lfsr_step = {fb, s[WIDTH-1:1]};
    end else begin
      // Galois: the bit falling off the top is XORed into the tapped positions.
      fb        = s[WIDTH-1];
      lfsr_step = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & TAPS);
    end
  endfunction

  logic [WIDTH-1:0] next_val;
  logic [IDX_W-1:0] cand;
  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] load_eff;

  // STEPS iterations chained combinationally so every advance costs one clock.
  always_comb begin
    next_val = val;
    for (int i = 0; i < STEPS; i++) begin
      next_val = lfsr_step(next_val);
    end
  end

  // The candidate comes from the state being advanced to. The bound is
  // sampled in this same cycle, so a changing limit takes effect immediately.
  assign cand   = next_val[IDX_W-1:0];
  assign accept = (limit == '0) || (cand < limit);

  // In RETRY the block advances every cycle regardless of update.
  assign advance = update || (state_q == RETRY);

  // A zero seed would lock the LFSR, so it is replaced by SEED.
  assign load_eff = (load_val == '0) ? SEED : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      val      <= SEED;
      rand_idx <= '0;
      idx_ok   <= 1'b1;
      state_q  <= IDLE;
    end else if (val == '0) begin
      // Lock-up recovery wins over load and advance. Only the state is
      // repaired. Any pending retry continues from SEED on the next cycle.
      val <= SEED;
    end else if (load) begin
      val     <= load_eff;
      idx_ok  <= 1'b1;
      state_q <= IDLE;
    end else if (advance) begin
      val <= next_val;
      if (accept) begin
        rand_idx <= cand;
        idx_ok   <= 1'b1;
        state_q  <= IDLE;
      end else begin
        idx_ok  <= 1'b0;
        state_q <= RETRY;
      end
    end
  end

  assign state_dbg = (state_q == RETRY);

endmodule

// File: tb/tb_lfsr_prng.sv
module tb_lfsr_prng;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        update;
  logic        load;
  logic [31:0] load_val;
  logic [2:0]  limit;

  // a: defaults (32-bit Fibonacci, IDX_W=2)
  logic [31:0] val_a;
  logic [1:0]  idx_a;
  logic        ok_a, st_a;
  // b: 8-bit Galois, STEPS=1, IDX_W=3
  logic [7:0]  val_b;
  logic [2:0]  idx_b;
  logic        ok_b, st_b;
  // c: 8-bit Galois, STEPS=2, IDX_W=3
  logic [7:0]  val_c;
  logic [2:0]  idx_c;
  logic        ok_c, st_c;

  lfsr_prng dut_a (
    .clk(clk), .rst(rst), .update(update), .load(load),
    .load_val(load_val), .limit(limit[1:0]),
    .val(val_a), .rand_idx(idx_a), .idx_ok(ok_a), .state_dbg(st_a)
  );

  lfsr_prng #(
    .WIDTH(8), .TAPS(8'h1D), .MODE(1), .SEED(8'hFF), .STEPS(1), .IDX_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .update(update), .load(load),
    .load_val(load_val[7:0]), .limit(limit),
    .val(val_b), .rand_idx(idx_b), .idx_ok(ok_b), .state_dbg(st_b)
  );

  lfsr_prng #(
    .WIDTH(8), .TAPS(8'h1D), .MODE(1), .SEED(8'hFF), .STEPS(2), .IDX_W(3)
  ) dut_c (
    .clk(clk), .rst(rst), .update(update), .load(load),
    .load_val(load_val[7:0]), .limit(limit),
    .val(val_c), .rand_idx(idx_c), .idx_ok(ok_c), .state_dbg(st_c)
  );

  // ---------------------------------------------------------------- reference model
  // Arithmetic model of the behaviour, one slot per instance.
  longint m_w[3]     = '{32, 8, 8};
  longint m_taps[3]  = '{64'h0820_0005, 64'h1D, 64'h1D};
  int     m_mode[3]  = '{0, 1, 1};
  longint m_seed[3]  = '{64'hDEAD_FACE, 64'hFF, 64'hFF};
  int     m_steps[3] = '{1, 1, 2};
  int     m_iw[3]    = '{2, 3, 3};

  longint mv[3];
  int     midx[3];
  bit     mok[3];
  bit     mretry[3];

  int n_checks = 0;
  int n_errors = 0;

  function automatic longint ref_step(int i, longint v);
    longint modw = longint'(1) << m_w[i];
    longint half = longint'(1) << (m_w[i] - 1);
    int     cnt  = 0;
    longint r;
    if (m_mode[i] == 0) begin
      for (int k = 0; k < m_w[i]; k++)
        if ((((v & m_taps[i]) >> k) & 1) == 1) cnt++;
      r = (cnt % 2) * half + v / 2;
    end else begin
      r = (v * 2) % modw;
      if (v >= half) r = r ^ m_taps[i];
    end
    return r;
  endfunction

  task automatic model_cycle(int i, bit r, bit u, bit l, logic [31:0] lv, logic [2:0] lim);
    longint modw  = longint'(1) << m_w[i];
    longint lvm   = longint'(lv) % modw;
    int     limi  = int'(lim) % (1 << m_iw[i]);
    longint nv;
    int     cand;
    if (r) begin
      mv[i] = m_seed[i]; midx[i] = 0; mok[i] = 1; mretry[i] = 0;
    end else if (mv[i] == 0) begin
      mv[i] = m_seed[i];
    end else if (l) begin
      mv[i] = (lvm == 0) ? m_seed[i] : lvm;
      mok[i] = 1; mretry[i] = 0;
    end else if (u || mretry[i]) begin
      nv = mv[i];
      for (int s = 0; s < m_steps[i]; s++) nv = ref_step(i, nv);
      mv[i] = nv;
      cand = int'(nv % (longint'(1) << m_iw[i]));
      if (limi == 0 || cand < limi) begin
        midx[i] = cand; mok[i] = 1; mretry[i] = 0;
      end else begin
        mok[i] = 0; mretry[i] = 1;
      end
    end
  endtask

  function automatic logic [36:0] model_pack(int i);
    return {mv[i][31:0], midx[i][2:0], mok[i], mretry[i]};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [110:0] exp_q[$];

  always @(posedge clk) begin
    logic [110:0] e;
    logic [36:0]  act;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {val_a, 1'b0, idx_a, ok_a, st_a};
      n_checks++;
      if (act !== e[110:74]) begin
        n_errors++;
        $display("FAIL sb_a t=%0t got val/idx/ok/st=%h expected %h", $time, act, e[110:74]);
      end
      act = {24'h0, val_b, idx_b, ok_b, st_b};
      n_checks++;
      if (act !== e[73:37]) begin
        n_errors++;
        $display("FAIL sb_b t=%0t got val/idx/ok/st=%h expected %h", $time, act, e[73:37]);
      end
      act = {24'h0, val_c, idx_c, ok_c, st_c};
      n_checks++;
      if (act !== e[36:0]) begin
        n_errors++;
        $display("FAIL sb_c t=%0t got val/idx/ok/st=%h expected %h", $time, act, e[36:0]);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic drive(bit r, bit u, bit l, logic [31:0] lv, logic [2:0] lim);
    rst = r; update = u; load = l; load_val = lv; limit = lim;
    for (int i = 0; i < 3; i++) model_cycle(i, r, u, l, lv, lim);
    exp_q.push_back({model_pack(0), model_pack(1), model_pack(2)});
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] seq_val[6] = '{8'hE3, 8'hDB, 8'hAB, 8'h4B, 8'h96, 8'h31};
  bit         seq_ok[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    bit saw_zero;
    bit r, l;
    logic [31:0] lv;

    // reset state
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("reset_val_a", val_a, 64'hDEAD_FACE);
    chk("reset_idx_a", idx_a, 0);
    chk("reset_ok_a", ok_a, 1);
    chk("reset_val_b", val_b, 64'hFF);

    // first update from reset
    drive(0, 1, 0, 0, 0);
    chk("upd1_val_a", val_a, 64'hEF56_FD67);
    chk("upd1_idx_a", idx_a, 3);
    chk("upd1_ok_a", ok_a, 1);
    chk("upd1_val_b", val_b, 64'hE3);
    chk("upd1_val_c", val_c, 64'hDB);

    // full period of the 8-bit Galois LFSR
    saw_zero = 0;
    for (int k = 0; k < 254; k++) begin
      drive(0, 1, 0, 0, 0);
      if (val_b == 8'h00) saw_zero = 1;
    end
    chk("period_val_b", val_b, 64'hFF);
    chk("period_no_zero_b", saw_zero, 0);

    // retry sequence with limit=3 from a single update pulse
    drive(1, 0, 0, 0, 3);
    drive(0, 1, 0, 0, 3);
    chk("retry_val_b0", val_b, seq_val[0]);
    chk("retry_ok_b0", ok_b, seq_ok[0]);
    for (int k = 1; k < 6; k++) begin
      drive(0, 0, 0, 0, 3);
      chk("retry_val_b", val_b, seq_val[k]);
      chk("retry_ok_b", ok_b, seq_ok[k]);
    end
    chk("retry_idx_b", idx_b, 1);
    chk("retry_idle_b", st_b, 0);

    // zero load together with update
    drive(0, 1, 1, 0, 3);
    chk("load0_val_b", val_b, 64'hFF);
    chk("load0_idx_b", idx_b, 1);
    chk("load0_ok_b", ok_b, 1);
    chk("load0_val_a", val_a, 64'hDEAD_FACE);

    // load aborts a retry
    drive(1, 0, 0, 0, 3);
    drive(0, 1, 0, 0, 3);
    chk("abort_pre_ok_b", ok_b, 0);
    drive(0, 0, 1, 32'h0000_0145, 3);
    chk("abort_ok_b", ok_b, 1);
    chk("abort_val_b", val_b, 64'h45);
    chk("abort_st_b", st_b, 0);
    chk("abort_val_a", val_a, 64'h145);

    // reset during a retry
    drive(1, 0, 0, 0, 3);
    drive(0, 1, 0, 0, 3);
    chk("rst_pre_st_b", st_b, 1);
    drive(1, 0, 0, 0, 3);
    chk("rst_val_b", val_b, 64'hFF);
    chk("rst_idx_b", idx_b, 0);
    chk("rst_ok_b", ok_b, 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      drive(r, 1'($urandom_range(0, 1)), l, lv, 3'($urandom_range(0, 7)));
    end

    drive(0, 0, 0, 0, 0);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
Parametrised LFSR pseudo-random generator. It supports Fibonacci and Galois forms, configurable width and taps, multiple steps per update, seed load and lock-up protection. It also has a bounded-index stage that uses rejection sampling to produce a uniform index in [0, limit). Cache-way replacement and TLB-random logic consume it.

Parameters:
WIDTH, 32, LFSR state width (>= 2)
TAPS, 32'h0820_0005, feedback tap mask, WIDTH bits
MODE, 0, 0 = Fibonacci, 1 = Galois
SEED, 32'hDEAD_FACE, reset/recovery state; must be non-zero
STEPS, 1, LFSR iterations per advance (>= 1), combinationally unrolled
IDX_W, 2, bounded-index width (1..WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
update  in  1  request a new random value/index
load  in  1  load load_val into state
load_val  in  WIDTH  seed to load
limit  in  IDX_W  index bound; 0 means full range 2^IDX_W
val  out  WIDTH  current LFSR state (register)
rand_idx  out  IDX_W  bounded random index (register)
idx_ok  out  1  rand_idx is fresh and the block is idle (register)

Behaviour:
- Reset: val=SEED, rand_idx=0, idx_ok=1, FSM state=IDLE.
- Priority each cycle: rst > load > advance.
- Single step, Fibonacci: fb = ^(val & TAPS); next = {fb, val[WIDTH-1:1]}.
- Single step, Galois: fb = val[WIDTH-1]; next = {val[WIDTH-2:0],1'b0} ^ ({WIDTH{fb}} & TAPS).
- Advance: val <= single step applied STEPS times (next_val). Latency is 1 cycle, with no bubbles.
- Lock-up rule: a load with load_val==0 loads SEED instead. If val is ever 0, the next clock forces val=SEED regardless of inputs (rst excepted).
- Load: val <= load_val (or SEED); FSM -> IDLE; rand_idx held; idx_ok <= 1. Load aborts RETRY.
- Candidate: cand = next_val[IDX_W-1:0]. It is accepted iff limit==0 or cand < limit; limit is sampled in the same cycle.
- FSM states are IDLE and RETRY.
  - IDLE with update=1: advance. If accepted: rand_idx<=cand, idx_ok<=1, stay IDLE. Else: rand_idx held, idx_ok<=0, go to RETRY.
  - IDLE with update=0: hold everything.
  - RETRY: advance every cycle whether or not update is asserted; update is absorbed. On accept: rand_idx<=cand, idx_ok<=1, go to IDLE. Else stay.
- While idx_ok=0, consumers must not use rand_idx.
- rand_idx is not re-checked when limit changes while IDLE. The consumer issues update after changing limit.
- A limit of 1 always accepts cand=0 only, so RETRY lasts until the low bits are 0. This terminates for any primitive TAPS with IDX_W <= WIDTH-1.
- Widths: all arithmetic is modulo 2^WIDTH. The comparison is unsigned on IDX_W bits.

Test Plan:
- Defaults (WIDTH=32, Fibonacci): reset, then one update -> val=32'hEF56_FD67. rand_idx=2'b11 (limit=0), idx_ok=1.
- WIDTH=8, MODE=1, TAPS=8'h1D, SEED=8'hFF, STEPS=1: one update -> val=8'hE3. Then 254 further updates -> val returns to 8'hFF, never 0 (period 255).
- Same config with IDX_W=3, limit=3, a single update pulse:
  - val sequence E3, DB, AB, 4B, 96, 31 on consecutive cycles.
  - idx_ok=0 for 5 cycles.
  - Then rand_idx=1, idx_ok=1, IDLE.
- Same config with STEPS=2: one update from reset -> val=8'hDB.
- load=1, load_val=0 together with update=1 -> val=SEED, rand_idx unchanged, idx_ok=1. load asserted mid-RETRY aborts the retry (idx_ok=1 next cycle).
- rst asserted mid-RETRY -> next cycle val=SEED, rand_idx=0, idx_ok=1.
